// File: rtl/hs_rr_sched.sv
// ---------------------------------------------------------------------------
// hs_rr_sched
//
// Purpose:
//   Clocked round-robin scheduler that lets M four-phase (req/ack/data)
//   producer channels share a single four-phase output channel. It is the
//   synchronous counterpart of a mutex/merge arbiter. The producers may be
//   clockless: every r_i bit and the returning a_o can pass through a
//   SYNC-stage synchronizer before the state machine looks at them.
//
//   One transaction walks IDLE -> REQ -> ACK -> RTZ -> IDLE:
//     IDLE : pick the first requesting channel starting at ptr, capture its
//            data into d_o, raise r_o.
//     REQ  : wait for the consumer acknowledge, then acknowledge the
//            producer on a_i[g].
//     ACK  : wait for the producer to drop its request, then drop r_o.
//     RTZ  : wait for the consumer acknowledge to drop, then drop a_i[g]
//            and move ptr just past the channel that was served.
//
// Parameters:
//   N    - data width per channel
//   M    - number of input channels (2..8)
//   SYNC - synchronizer depth on r_i and a_o (0 = raw inputs, 2 or 3)
//
// Ports:
//   clk    in   1      clock, all state changes on its rising edge
//   rst    in   1      asynchronous active-high reset
//   r_i    in   M      per-channel four-phase request
//   a_i    out  M      per-channel acknowledge (registered, one-hot or zero)
//   d_i    in   M*N    channel k data in bits [k*N+N-1 : k*N]
//   r_o    out  1      output request (registered)
//   a_o    in   1      output acknowledge
//   d_o    out  N      output data (registered, held for the transaction)
//   gnt_o  out  W      index of the channel currently granted
//   busy_o out  1      high whenever the state machine is not in IDLE
// ---------------------------------------------------------------------------
module hs_rr_sched #(
  parameter int N    = 1,
  parameter int M    = 4,
  parameter int SYNC = 2,
  localparam int W   = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   r_i,
  output logic [M-1:0]   a_i,
  input  logic [M*N-1:0] d_i,
  output logic           r_o,
  input  logic           a_o,
  output logic [N-1:0]   d_o,
  output logic [W-1:0]   gnt_o,
  output logic           busy_o
);

  // State encoding kept as plain constants so the block drops into older
  // flows that do not handle enumerated types.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_RTZ  = 2'd3;

  // Synchronized views of the asynchronous handshake inputs.
  logic [M-1:0] rs;
  logic         as;

  // -------------------------------------------------------------------------
  // Input synchronizers. With SYNC=0 the inputs are assumed to already be
  // clock-domain clean and feed the state machine directly.
  // -------------------------------------------------------------------------
  generate
    if (SYNC == 0) begin : g_nosync
      assign rs = r_i;
      assign as = a_o;
    end else begin : g_sync
      logic [M-1:0]    r_sync_q [SYNC];
      logic [M-1:0]    r_sync_d [SYNC];
      logic [SYNC-1:0] a_sync_q;
      logic [SYNC-1:0] a_sync_d;

      // Plain shift chains: stage 0 samples the raw input, each later stage
      // copies the one before it.
      always_comb begin
        for (int s = 0; s < SYNC; s++) begin
          r_sync_d[s] = '0;
        end
        a_sync_d = '0;
        r_sync_d[0] = r_i;
        a_sync_d[0] = a_o;
        for (int s = 1; s < SYNC; s++) begin
          r_sync_d[s] = r_sync_q[s-1];
          a_sync_d[s] = a_sync_q[s-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC; s++) begin
            r_sync_q[s] <= '0;
          end
          a_sync_q <= '0;
        end else begin
          for (int s = 0; s < SYNC; s++) begin
            r_sync_q[s] <= r_sync_d[s];
          end
          a_sync_q <= a_sync_d;
        end
      end

      assign rs = r_sync_q[SYNC-1];
      assign as = a_sync_q[SYNC-1];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Unpack the flat data bus into one word per channel.
  // -------------------------------------------------------------------------
  logic [N-1:0] d_arr [M];

  generate
    for (genvar k = 0; k < M; k++) begin : g_unpack
      assign d_arr[k] = d_i[k*N +: N];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registered state.
  // -------------------------------------------------------------------------
  logic [1:0]   state_q, state_d;
  logic [W-1:0] ptr_q,   ptr_d;
  logic [W-1:0] gnt_q,   gnt_d;
  logic [N-1:0] d_o_q,   d_o_d;
  logic         r_o_q,   r_o_d;
  logic [M-1:0] a_i_q,   a_i_d;

  // -------------------------------------------------------------------------
  // Round-robin selection: walk the channels starting at ptr and wrapping
  // modulo M; the first synchronized request found wins. The candidate index
  // is computed one bit wider than W so the wrap test works for any M.
  // -------------------------------------------------------------------------
  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [W:0]   cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int j = 0; j < M; j++) begin
      cand = {1'b0, ptr_q} + (W+1)'(j);
      if (cand >= (W+1)'(M)) begin
        cand = cand - (W+1)'(M);
      end
      if (!sel_found && rs[cand[W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[W-1:0];
      end
    end
  end

  // Helpers derived from the latched grant: its one-hot acknowledge and the
  // index just past it, which becomes the next scan start.
  logic [M-1:0] gnt_onehot;
  logic [W-1:0] gnt_next;

  always_comb begin
    gnt_onehot = {{(M-1){1'b0}}, 1'b1} << gnt_q;
    gnt_next   = (gnt_q == W'(M-1)) ? '0 : gnt_q + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Handshake sequencer. Every transition waits only on synchronized inputs,
  // so each response lands SYNC+1 edges after the raw input moved. The data
  // word is captured only when leaving IDLE; d_i may change freely after
  // that. A producer that drops its request early while we sit in REQ is
  // simply noticed later in ACK.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    d_o_d   = d_o_q;
    r_o_d   = r_o_q;
    a_i_d   = a_i_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          d_o_d   = d_arr[sel_idx];
          r_o_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (as) begin
          a_i_d   = gnt_onehot;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!rs[gnt_q]) begin
          r_o_d   = 1'b0;
          state_d = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (!as) begin
          a_i_d   = '0;
          ptr_d   = gnt_next;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset clears every output immediately, including mid-transaction; the
  // producers and the consumer are expected to be reset alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      d_o_q   <= '0;
      r_o_q   <= 1'b0;
      a_i_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      d_o_q   <= d_o_d;
      r_o_q   <= r_o_d;
      a_i_q   <= a_i_d;
    end
  end

  assign a_i    = a_i_q;
  assign r_o    = r_o_q;
  assign d_o    = d_o_q;
  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_hs_rr_sched
//
// Exercises two instances of hs_rr_sched (M=4, N=8): one with no input
// synchronizers and one with two-stage synchronizers. The bench plays both
// the producers and the consumer. Expected grants come from a small
// round-robin model over the set of pending requests.
// ---------------------------------------------------------------------------
module tb_hs_rr_sched;

  logic clk;
  logic clk_en;
  logic rst;

  // Instance without synchronizers.
  logic [3:0]  r_i0;
  logic [3:0]  a_i0;
  logic [31:0] d_i0;
  logic        r_o0;
  logic        a_o0;
  logic [7:0]  d_o0;
  logic [1:0]  gnt0;
  logic        busy0;

  // Instance with two-stage synchronizers.
  logic [3:0]  r_i2;
  logic [3:0]  a_i2;
  logic [31:0] d_i2;
  logic        r_o2;
  logic        a_o2;
  logic [7:0]  d_o2;
  logic [1:0]  gnt2;
  logic        busy2;

  int total;
  int bad;

  hs_rr_sched #(.N(8), .M(4), .SYNC(0)) dut0 (
    .clk(clk), .rst(rst), .r_i(r_i0), .a_i(a_i0), .d_i(d_i0),
    .r_o(r_o0), .a_o(a_o0), .d_o(d_o0), .gnt_o(gnt0), .busy_o(busy0)
  );

  hs_rr_sched #(.N(8), .M(4), .SYNC(2)) dut2 (
    .clk(clk), .rst(rst), .r_i(r_i2), .a_i(a_i2), .d_i(d_i2),
    .r_o(r_o2), .a_o(a_o2), .d_o(d_o2), .gnt_o(gnt2), .busy_o(busy2)
  );

  // Gateable clock so reset can be applied with the clock frozen low.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Absolute time limit.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Round-robin reference: first pending channel scanning p, p+1, ... mod 4.
  function automatic int rr_pick(input logic [3:0] pend, input int p);
    for (int j = 0; j < 4; j++) begin
      if (pend[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset;
    rst  = 1'b1;
    r_i0 = '0; d_i0 = '0; a_o0 = 1'b0;
    r_i2 = '0; d_i2 = '0; a_o2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Consumer + producer behaviour for one transaction on the SYNC=0 instance.
  // Reports the granted index, captured data, whether d_o stayed put, whether
  // any other a_i bit rose, and whether a wait ran out.
  task automatic serve0(input bit rearm, input logic [3:0] new_mask,
                        input logic [31:0] new_data, output int gnt,
                        output logic [7:0] dat, output bit stable,
                        output bit stray, output bit to);
    int n;
    logic [3:0] own;
    gnt = -1; dat = '0; stable = 1'b1; stray = 1'b0; to = 1'b0;
    n = 0;
    while (r_o0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (r_o0 !== 1'b1) begin to = 1'b1; return; end
    gnt = int'(gnt0);
    dat = d_o0;
    own = 4'b0001 << gnt;
    repeat ($urandom_range(0, 2)) begin
      d_i0[gnt*8 +: 8] = 8'($urandom);
      @(negedge clk);
      if (d_o0 !== dat) stable = 1'b0;
      if ((a_i0 & ~own) != 4'b0) stray = 1'b1;
    end
    a_o0 = 1'b1;
    n = 0;
    while (a_i0 === 4'b0 && n < 100) begin
      @(negedge clk); n++;
      if (d_o0 !== dat) stable = 1'b0;
      if ((a_i0 & ~own) != 4'b0) stray = 1'b1;
    end
    if (a_i0 === 4'b0) begin to = 1'b1; return; end
    for (int k = 0; k < 4; k++) begin
      if (new_mask[k]) begin
        d_i0[k*8 +: 8] = new_data[k*8 +: 8];
        r_i0[k] = 1'b1;
      end
    end
    r_i0[gnt] = 1'b0;
    n = 0;
    while (r_o0 !== 1'b0 && n < 100) begin
      @(negedge clk); n++;
      if (d_o0 !== dat) stable = 1'b0;
      if ((a_i0 & ~own) != 4'b0) stray = 1'b1;
    end
    if (r_o0 !== 1'b0) begin to = 1'b1; return; end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    a_o0 = 1'b0;
    n = 0;
    while (a_i0 !== 4'b0 && n < 100) begin
      @(negedge clk); n++;
      if (d_o0 !== dat) stable = 1'b0;
      if ((a_i0 & ~own) != 4'b0) stray = 1'b1;
    end
    if (a_i0 !== 4'b0) begin to = 1'b1; return; end
    if (rearm) begin
      d_i0[gnt*8 +: 8] = 8'($urandom);
      r_i0[gnt] = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(negedge clk);
    total++; if (r_o0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_r_o got=%b want=0", r_o0); end
    total++; if (a_i0 !== 4'b0) begin bad++; $display("[TB] FAIL reset_a_i got=%b want=0000", a_i0); end
    total++; if (d_o0 !== 8'h00) begin bad++; $display("[TB] FAIL reset_d_o got=%h want=00", d_o0); end
    total++; if (gnt0 !== 2'd0) begin bad++; $display("[TB] FAIL reset_gnt got=%0d want=0", gnt0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy0); end
    total++; if ({r_o2, a_i2, busy2} !== 6'b0) begin bad++; $display("[TB] FAIL reset_sync2 got=%b want=0", {r_o2, a_i2, busy2}); end
    rst = 1'b0;
    @(negedge clk);
    // Bring a transaction into ACK, then reset with the clock frozen.
    d_i0[23:16] = 8'hC3;
    r_i0[2] = 1'b1;
    n = 0;
    while (r_o0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    a_o0 = 1'b1;
    n = 0;
    while (a_i0 === 4'b0 && n < 20) begin @(negedge clk); n++; end
    total++; if (a_i0 !== 4'b0100 || d_o0 !== 8'hC3) begin bad++; $display("[TB] FAIL pre_reset_ack got a_i=%b d_o=%h want a_i=0100 d_o=c3", a_i0, d_o0); end
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (r_o0 !== 1'b0) begin bad++; $display("[TB] FAIL async_r_o got=%b want=0", r_o0); end
    total++; if (a_i0 !== 4'b0) begin bad++; $display("[TB] FAIL async_a_i got=%b want=0000", a_i0); end
    total++; if (d_o0 !== 8'h00) begin bad++; $display("[TB] FAIL async_d_o got=%h want=00", d_o0); end
    total++; if (gnt0 !== 2'd0) begin bad++; $display("[TB] FAIL async_gnt got=%0d want=0", gnt0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL async_busy got=%b want=0", busy0); end
    r_i0 = '0; a_o0 = 1'b0; d_i0 = '0;
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy0 !== 1'b0 || r_o0 !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle got busy=%b r_o=%b want 0 0", busy0, r_o0); end
  endtask

  task automatic test_single;
    int n1, n2, n3, n4, g;
    logic [7:0] dv;
    bit st, sy, to;
    do_reset;
    d_i0[15:8] = 8'h5A;
    r_i0[1] = 1'b1;
    n1 = 0; do begin @(negedge clk); n1++; end while (r_o0 !== 1'b1 && n1 < 20);
    total++; if (n1 !== 1) begin bad++; $display("[TB] FAIL single_req_lat got=%0d want=1", n1); end
    total++; if (d_o0 !== 8'h5A) begin bad++; $display("[TB] FAIL single_data got=%h want=5a", d_o0); end
    total++; if (gnt0 !== 2'd1) begin bad++; $display("[TB] FAIL single_gnt got=%0d want=1", gnt0); end
    a_o0 = 1'b1;
    n2 = 0; do begin @(negedge clk); n2++; end while (a_i0 !== 4'b0010 && n2 < 20);
    total++; if (n2 !== 1) begin bad++; $display("[TB] FAIL single_ack_lat got=%0d want=1", n2); end
    r_i0[1] = 1'b0;
    n3 = 0; do begin @(negedge clk); n3++; end while (r_o0 !== 1'b0 && n3 < 20);
    total++; if (n3 !== 1) begin bad++; $display("[TB] FAIL single_rtz_lat got=%0d want=1", n3); end
    a_o0 = 1'b0;
    n4 = 0; do begin @(negedge clk); n4++; end while (a_i0 !== 4'b0 && n4 < 20);
    total++; if (n1 + n2 + n3 + n4 !== 4 || busy0 !== 1'b0) begin bad++; $display("[TB] FAIL single_cycle got clocks=%0d busy=%b want clocks=4 busy=0", n1 + n2 + n3 + n4, busy0); end
    // ptr now 2: with channels 1 and 3 pending, 3 must win.
    d_i0[15:8] = 8'h11; d_i0[31:24] = 8'h33;
    r_i0[1] = 1'b1; r_i0[3] = 1'b1;
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 3 || dv !== 8'h33) begin bad++; $display("[TB] FAIL single_ptr got gnt=%0d d=%h to=%b want gnt=3 d=33 to=0", g, dv, to); end
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 1 || dv !== 8'h11) begin bad++; $display("[TB] FAIL single_ptr2 got gnt=%0d d=%h to=%b want gnt=1 d=11 to=0", g, dv, to); end
  endtask

  task automatic test_simultaneous;
    int g;
    logic [7:0] dv;
    bit st, sy, to;
    do_reset;
    d_i0[7:0] = 8'hA0; d_i0[23:16] = 8'hA2;
    r_i0[0] = 1'b1; r_i0[2] = 1'b1;
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 0 || dv !== 8'hA0) begin bad++; $display("[TB] FAIL simul_first got gnt=%0d d=%h to=%b want gnt=0 d=a0 to=0", g, dv, to); end
    total++; if (sy !== 1'b0) begin bad++; $display("[TB] FAIL simul_other_ack got stray=%b want 0", sy); end
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 2 || dv !== 8'hA2) begin bad++; $display("[TB] FAIL simul_second got gnt=%0d d=%h to=%b want gnt=2 d=a2 to=0", g, dv, to); end
  endtask

  task automatic test_fairness;
    int g, p, expg;
    logic [7:0] dv;
    bit st, sy, to;
    do_reset;
    d_i0 = 32'h4433_2211;
    r_i0 = 4'hF;
    p = 0;
    for (int t = 0; t < 8; t++) begin
      expg = rr_pick(4'hF, p);
      serve0(1'b1, 4'b0, 32'b0, g, dv, st, sy, to);
      total++; if (to !== 1'b0 || g !== expg) begin bad++; $display("[TB] FAIL fair_order t=%0d got gnt=%0d to=%b want gnt=%0d", t, g, to, expg); end
      total++; if (st !== 1'b1 || sy !== 1'b0) begin bad++; $display("[TB] FAIL fair_data_hold t=%0d got stable=%b stray=%b want 1 0", t, st, sy); end
      p = (expg + 1) % 4;
    end
  endtask

  task automatic test_reset_ack;
    int n, g;
    logic [7:0] dv;
    bit st, sy, to;
    do_reset;
    d_i0[23:16] = 8'h22;
    r_i0[2] = 1'b1;
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 2) begin bad++; $display("[TB] FAIL rstack_setup got gnt=%0d to=%b want 2 0", g, to); end
    d_i0[31:24] = 8'h77;
    r_i0[3] = 1'b1;
    n = 0;
    while (r_o0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    a_o0 = 1'b1;
    n = 0;
    while (a_i0 === 4'b0 && n < 20) begin @(negedge clk); n++; end
    total++; if (a_i0 !== 4'b1000) begin bad++; $display("[TB] FAIL rstack_in_ack got a_i=%b want 1000", a_i0); end
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (a_i0 !== 4'b0 || r_o0 !== 1'b0) begin bad++; $display("[TB] FAIL rstack_async got a_i=%b r_o=%b want 0000 0", a_i0, r_o0); end
    r_i0 = '0; a_o0 = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d_i0[15:8] = 8'h55; d_i0[31:24] = 8'h99;
    r_i0[1] = 1'b1; r_i0[3] = 1'b1;
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== rr_pick(4'b1010, 0) || dv !== 8'h55) begin bad++; $display("[TB] FAIL rstack_rescan got gnt=%0d d=%h to=%b want gnt=1 d=55 to=0", g, dv, to); end
    serve0(1'b0, 4'b0, 32'b0, g, dv, st, sy, to);
    total++; if (to !== 1'b0 || g !== 3) begin bad++; $display("[TB] FAIL rstack_next got gnt=%0d to=%b want 3 0", g, to); end
  endtask

  // Waits on the SYNC=2 instance for one handshake phase, counting edges and
  // watching for any a_i value other than idle or the expected one-hot.
  task automatic wait2(input int phase, output int n, inout bit glitch);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (a_i2 !== 4'b0 && a_i2 !== 4'b0010) glitch = 1'b1;
      case (phase)
        0: done = (r_o2 === 1'b1);
        1: done = (a_i2 === 4'b0010);
        2: done = (r_o2 === 1'b0);
        default: done = (a_i2 === 4'b0);
      endcase
    end
  endtask

  task automatic test_sync2;
    int n1, n2, n3, n4;
    bit glitch;
    do_reset;
    glitch = 1'b0;
    d_i2[15:8] = 8'h5A;
    r_i2[1] = 1'b1;
    wait2(0, n1, glitch);
    total++; if (n1 !== 3) begin bad++; $display("[TB] FAIL sync2_req_lat got=%0d want=3", n1); end
    total++; if (d_o2 !== 8'h5A || gnt2 !== 2'd1) begin bad++; $display("[TB] FAIL sync2_grant got d=%h gnt=%0d want 5a 1", d_o2, gnt2); end
    a_o2 = 1'b1;
    wait2(1, n2, glitch);
    total++; if (n2 !== 3) begin bad++; $display("[TB] FAIL sync2_ack_lat got=%0d want=3", n2); end
    r_i2[1] = 1'b0;
    wait2(2, n3, glitch);
    total++; if (n3 !== 3) begin bad++; $display("[TB] FAIL sync2_rtz_lat got=%0d want=3", n3); end
    a_o2 = 1'b0;
    wait2(3, n4, glitch);
    total++; if (n4 !== 3) begin bad++; $display("[TB] FAIL sync2_release_lat got=%0d want=3", n4); end
    total++; if (n1 + n2 + n3 + n4 !== 12 || busy2 !== 1'b0) begin bad++; $display("[TB] FAIL sync2_cycle got clocks=%0d busy=%b want 12 0", n1 + n2 + n3 + n4, busy2); end
    total++; if (glitch !== 1'b0) begin bad++; $display("[TB] FAIL sync2_ack_glitch got=%b want=0", glitch); end
  endtask

  task automatic test_random;
    logic [3:0]  pend, nm, own;
    logic [7:0]  data [4];
    logic [31:0] nd;
    logic [7:0]  dv;
    int p, expg, g;
    bit st, sy, to;
    do_reset;
    p = 0;
    pend = 4'($urandom_range(1, 15));
    for (int k = 0; k < 4; k++) begin
      data[k] = 8'($urandom);
      if (pend[k]) begin
        d_i0[k*8 +: 8] = data[k];
        r_i0[k] = 1'b1;
      end
    end
    for (int t = 0; t < 24; t++) begin
      expg = rr_pick(pend, p);
      own  = 4'b0001 << expg;
      nm   = 4'($urandom) & ~pend;
      if ((pend & ~own) == 4'b0 && nm == 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (!pend[k] && nm == 4'b0) nm[k] = 1'b1;
        end
      end
      nd = $urandom;
      serve0(1'b0, nm, nd, g, dv, st, sy, to);
      total++; if (to !== 1'b0 || g !== expg) begin bad++; $display("[TB] FAIL rand_gnt t=%0d got=%0d to=%b want=%0d", t, g, to, expg); end
      total++; if (dv !== data[expg]) begin bad++; $display("[TB] FAIL rand_data t=%0d got=%h want=%h", t, dv, data[expg]); end
      total++; if (st !== 1'b1 || sy !== 1'b0) begin bad++; $display("[TB] FAIL rand_hold t=%0d got stable=%b stray=%b want 1 0", t, st, sy); end
      pend[expg] = 1'b0;
      p = (expg + 1) % 4;
      for (int k = 0; k < 4; k++) begin
        if (nm[k]) begin
          pend[k] = 1'b1;
          data[k] = nd[k*8 +: 8];
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; clk_en = 1'b1; rst = 1'b1;
    r_i0 = '0; d_i0 = '0; a_o0 = 1'b0;
    r_i2 = '0; d_i2 = '0; a_o2 = 1'b0;
    test_reset;
    test_single;
    test_simultaneous;
    test_fairness;
    test_reset_ack;
    test_sync2;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
